// File: rtl/jay_pkg.sv
// rtl/jay_pkg.sv - shared types and program entry/end table for the JAY sequencer
package jay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int NTAB = 4;
  localparam int PROG_ENTRY [NTAB] = '{0, 128, 256, 384};
  localparam int PROG_END   [NTAB] = '{127, 255, 383, 511};

  // Programs beyond the default table continue the 128-word slot layout.
  function automatic int prog_entry_of(input int idx);
    if (idx < NTAB) return PROG_ENTRY[idx];
    return idx * 128;
  endfunction

  function automatic int prog_end_of(input int idx);
    if (idx < NTAB) return PROG_END[idx];
    return idx * 128 + 127;
  endfunction

endpackage

// File: rtl/prog_entry_lut.sv
// rtl/prog_entry_lut.sv - combinational program select to entry/end address lookup
module prog_entry_lut
  import jay_pkg::*;
#(
  parameter int D      = 12,
  parameter int NPROG  = 4,
  parameter int PSEL_W = $clog2(NPROG)
) (
  input  logic [PSEL_W-1:0] sel,
  output logic [D-1:0]      entry_addr,
  output logic [D-1:0]      end_addr
);

  // Out-of-range selects fall back to program 0.
  always_comb begin
    entry_addr = D'(prog_entry_of(0));
    end_addr   = D'(prog_end_of(0));
    if (int'(sel) < NPROG) begin
      entry_addr = D'(prog_entry_of(int'(sel)));
      end_addr   = D'(prog_end_of(int'(sel)));
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - host-handshaked program sequencer with jumps, halt, stall and timeout
module run_sequencer
  import jay_pkg::*;
#(
  parameter int D      = 12,
  parameter int NPROG  = 4,
  parameter int PSEL_W = $clog2(NPROG),
  parameter int OFF_W  = 8,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [PSEL_W-1:0] prog_sel,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              absjump_en,
  input  logic [D-1:0]      target,
  input  logic              reljump_en,
  input  logic [OFF_W-1:0]  rel_off,
  output logic [D-1:0]      prog_ctr,
  output logic              fetch_en,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [TMO_W-1:0]  cycles
);

  seq_state_t        state_q, state_d;
  logic [PSEL_W-1:0] sel_q, sel_d;
  logic [D-1:0]      pc_q, pc_d;
  logic [TMO_W-1:0]  cyc_q, cyc_d;
  logic              tmo_q, tmo_d;
  logic [D-1:0]      entry_addr, end_addr;
  logic [D-1:0]      rel_ext;

  prog_entry_lut #(
    .D      (D),
    .NPROG  (NPROG),
    .PSEL_W (PSEL_W)
  ) u_lut (
    .sel        (sel_q),
    .entry_addr (entry_addr),
    .end_addr   (end_addr)
  );

  assign rel_ext = D'($signed(rel_off));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      pc_q    <= '0;
      cyc_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          sel_d   = prog_sel;
          state_d = LOAD;
        end
      end
      LOAD: begin
        pc_d    = entry_addr;
        cyc_d   = '0;
        tmo_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cyc_q == {TMO_W{1'b1}}) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
          // Jumps take precedence over the end check, so a jump at end is honoured.
          if (stall_i) begin
            pc_d = pc_q;
          end else if (halt_i) begin
            state_d = DONE;
          end else if (absjump_en) begin
            pc_d = target;
          end else if (reljump_en) begin
            pc_d = pc_q + rel_ext;
          end else if (pc_q == end_addr) begin
            state_d = DONE;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prog_ctr = pc_q;
  assign cycles   = cyc_q;
  assign fetch_en = (state_q == RUN);
  assign busy     = (state_q == LOAD) || (state_q == RUN);
  assign done     = (state_q == DONE);
  assign timeout  = tmo_q && (state_q == DONE);

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - scoreboard bench for run_sequencer (default and 4-bit timeout instances)
module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req2;
  logic [1:0]  prog_sel;
  logic        stall_i, halt_i, absjump_en, reljump_en;
  logic [11:0] target;
  logic [7:0]  rel_off;

  logic [11:0] pc_a, pc_b;
  logic        fe_a, fe_b, busy_a, busy_b, done_a, done_b, tmo_a, tmo_b;
  logic [15:0] cyc_a;
  logic [3:0]  cyc_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          at;
    int          inst;
    string       name;
    logic [11:0] pc;
    logic        d, b, f, t;
    logic [15:0] cy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  run_sequencer dut_a (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
    .stall_i(stall_i), .halt_i(halt_i), .absjump_en(absjump_en), .target(target),
    .reljump_en(reljump_en), .rel_off(rel_off), .prog_ctr(pc_a), .fetch_en(fe_a),
    .busy(busy_a), .done(done_a), .timeout(tmo_a), .cycles(cyc_a)
  );

  run_sequencer #(.TMO_W(4)) dut_b (
    .clk(clk), .reset(reset), .req(req2), .prog_sel(prog_sel),
    .stall_i(stall_i), .halt_i(halt_i), .absjump_en(absjump_en), .target(target),
    .reljump_en(reljump_en), .rel_off(rel_off), .prog_ctr(pc_b), .fetch_en(fe_b),
    .busy(busy_b), .done(done_b), .timeout(tmo_b), .cycles(cyc_b)
  );

  // Monitor: compares every queued expectation stamped for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      logic [11:0] p;
      logic        d, b, f, t;
      logic [15:0] cy;
      e = sb.pop_front();
      if (e.inst == 0) begin
        p = pc_a; d = done_a; b = busy_a; f = fe_a; t = tmo_a; cy = cyc_a;
      end else begin
        p = pc_b; d = done_b; b = busy_b; f = fe_b; t = tmo_b; cy = {12'd0, cyc_b};
      end
      n_cmp++;
      if (e.at != cyc || p !== e.pc || d !== e.d || b !== e.b || f !== e.f || t !== e.t || cy !== e.cy) begin
        n_bad++;
        $display("FAIL %s: got pc=%h done=%b busy=%b fetch=%b tmo=%b cycles=%0d, want pc=%h done=%b busy=%b fetch=%b tmo=%b cycles=%0d",
                 e.name, p, d, b, f, t, cy, e.pc, e.d, e.b, e.f, e.t, e.cy);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_now(input string name, input int inst, input logic [11:0] pc,
                            input logic d, input logic b, input logic f, input logic t,
                            input logic [15:0] cy);
    exp_t e;
    e.at = cyc; e.inst = inst; e.name = name; e.pc = pc;
    e.d = d; e.b = b; e.f = f; e.t = t; e.cy = cy;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b0; req = 1'b1; req2 = 1'b0; prog_sel = 2'd1;
    stall_i = 0; halt_i = 0; absjump_en = 0; reljump_en = 0;
    target = '0; rel_off = '0;
    tick(2);
    expect_now("reset_a", 0, 12'h000, 0, 0, 0, 0, 16'd0);
    expect_now("reset_b", 1, 12'h000, 0, 0, 0, 0, 16'd0);

    // Program 1, straight-line run to its end address.
    reset = 1'b1;
    tick(1);
    expect_now("load", 0, 12'h000, 0, 1, 0, 0, 16'd0);
    tick(1);
    expect_now("first_fetch", 0, 12'd128, 0, 1, 1, 0, 16'd0);
    tick(127);
    expect_now("at_end", 0, 12'd255, 0, 1, 1, 0, 16'd127);
    tick(1);
    expect_now("done_p1", 0, 12'd255, 1, 0, 0, 0, 16'd128);
    req = 1'b0;
    tick(1);
    expect_now("done_drop", 0, 12'd255, 0, 0, 0, 0, 16'd128);

    // Program 0: relative, absolute and wrapping jumps.
    req = 1'b1; prog_sel = 2'd0;
    tick(2);
    expect_now("p0_start", 0, 12'h000, 0, 1, 1, 0, 16'd0);
    tick(5);
    reljump_en = 1; rel_off = 8'hFD;
    tick(1);
    expect_now("rel_m3", 0, 12'h002, 0, 1, 1, 0, 16'd6);
    absjump_en = 1; target = 12'h0A0;
    tick(1);
    expect_now("abs_wins", 0, 12'h0A0, 0, 1, 1, 0, 16'd7);
    reljump_en = 0; target = 12'h002;
    tick(1);
    absjump_en = 0; reljump_en = 1; rel_off = 8'hF8;
    tick(1);
    expect_now("rel_wrap", 0, 12'hFFA, 0, 1, 1, 0, 16'd9);
    reljump_en = 0; absjump_en = 1; target = 12'h00A;
    tick(1);
    expect_now("abs_10", 0, 12'h00A, 0, 1, 1, 0, 16'd10);

    // Stall masks halt; halt takes effect once stall releases.
    absjump_en = 0; stall_i = 1; halt_i = 1;
    tick(3);
    expect_now("stall_hold", 0, 12'h00A, 0, 1, 1, 0, 16'd13);
    stall_i = 0;
    tick(1);
    expect_now("halt_done", 0, 12'h00A, 1, 0, 0, 0, 16'd14);
    halt_i = 0; req = 1'b0;
    tick(1);
    expect_now("halt_drop", 0, 12'h00A, 0, 0, 0, 0, 16'd14);

    // Abort by dropping req, then reset mid-run.
    req = 1'b1; prog_sel = 2'd2;
    tick(2);
    expect_now("p2_start", 0, 12'd256, 0, 1, 1, 0, 16'd0);
    tick(3);
    req = 1'b0;
    tick(1);
    expect_now("abort", 0, 12'd259, 0, 0, 0, 0, 16'd3);
    req = 1'b1; prog_sel = 2'd3;
    tick(4);
    expect_now("p3_run", 0, 12'd386, 0, 1, 1, 0, 16'd2);
    reset = 1'b0;
    tick(1);
    expect_now("reset_mid", 0, 12'h000, 0, 0, 0, 0, 16'd0);
    reset = 1'b1; req = 1'b0; prog_sel = 2'd0;

    // Saturating timeout on the 4-bit-counter instance.
    req2 = 1'b1; reljump_en = 1; rel_off = 8'h00;
    tick(2);
    expect_now("tmo_start", 1, 12'h000, 0, 1, 1, 0, 16'd0);
    tick(15);
    expect_now("tmo_sat", 1, 12'h000, 0, 1, 1, 0, 16'd15);
    tick(1);
    expect_now("tmo_done", 1, 12'h000, 1, 0, 0, 1, 16'd15);
    req2 = 1'b0; reljump_en = 0;
    tick(1);
    expect_now("tmo_drop", 1, 12'h000, 0, 0, 0, 0, 16'd15);

    tick(2);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
